sha_apb_initiator: RTL

SHA_APB_INITIATOR -- requirements
Module: sha_apb_initiator

---
 rtl/sha_apb_pkg.sv | 21 ++
 rtl/sha_apb_initiator.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sha_apb_pkg.sv
// Shared definitions for the SHA peripheral APB initiator: FSM state encoding
// and the register map of the SHA peripheral it talks to.
package sha_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Byte offsets of the SHA peripheral registers inside its 4KB APB window
    localparam logic [11:0] SHA_CTRL_OFFSET    = 12'h004;
    localparam logic [11:0] SHA_CMD_OFFSET     = 12'h008;
    localparam logic [11:0] SHA_STATUS_OFFSET  = 12'h00C;
    localparam logic [11:0] SHA_ADDRESS_OFFSET = 12'h010;
    localparam logic [11:0] SHA_MESSAGE_OFFSET = 12'h014;
    localparam logic [11:0] SHA_RW_OFFSET      = 12'h018;
    localparam logic [11:0] SHA_DIGEST_OFFSET  = 12'h01C;

endpackage

// File: rtl/sha_apb_initiator.sv
// Single-outstanding APB master: takes one command, runs SETUP/ACCESS on the
// bus, and holds the response until the consumer takes it.
module sha_apb_initiator
    import sha_apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,

    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    apb_state_e                state_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q;
    logic                      write_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      cmdReady_q;
    logic                      rspValid_q;
    logic [31:0]               rspRdata_q;
    logic                      rspErr_q;
    logic                      rspTimeout_q;
    logic [7:0]                waitCnt_q;
    logic [7:0]                waitCnt_d;
    logic                      timeoutHit;

    // The ACCESS cycle that would bring the count to the limit is the last one allowed
    always_comb begin
        waitCnt_d  = waitCnt_q + 8'd1;
        timeoutHit = (waitCnt_d == TimeoutLimit);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            cmdReady_q   <= 1'b1;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= '0;
            rspErr_q     <= 1'b0;
            rspTimeout_q <= 1'b0;
            waitCnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q     <= cmd_addr_i;
                        write_q    <= cmd_write_i;
                        wdata_q    <= cmd_wdata_i;
                        waitCnt_q  <= '0;
                        psel_q     <= 1'b1;
                        cmdReady_q <= 1'b0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A slave answering on the final allowed cycle still counts as on time
                    if (PREADY) begin
                        rspRdata_q   <= write_q ? 32'd0 : PRDATA;
                        rspErr_q     <= PSLVERR;
                        rspTimeout_q <= 1'b0;
                        rspValid_q   <= 1'b1;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        state_q      <= RESP;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                        if (timeoutHit) begin
                            rspRdata_q   <= 32'd0;
                            rspErr_q     <= 1'b1;
                            rspTimeout_q <= 1'b1;
                            rspValid_q   <= 1'b1;
                            psel_q       <= 1'b0;
                            penable_q    <= 1'b0;
                            state_q      <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rspValid_q <= 1'b0;
                        cmdReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    psel_q     <= 1'b0;
                    penable_q  <= 1'b0;
                    rspValid_q <= 1'b0;
                    cmdReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmdReady_q;
    assign rsp_valid_o   = rspValid_q;
    assign rsp_rdata_o   = rspRdata_q;
    assign rsp_err_o     = rspErr_q;
    assign rsp_timeout_o = rspTimeout_q;
    assign PADDR         = addr_q;
    assign PWDATA        = wdata_q;
    assign PWRITE        = write_q;
    assign PSEL          = psel_q;
    assign PENABLE       = penable_q;

endmodule
